// File: rtl/dn_pkg.sv
// Shared definitions for the ROM download sourcing path.
package dn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_FIN  = 2'd3
  } dn_state_t;

  localparam logic [7:0] IDX_PGROM = 8'd0;
  localparam logic [7:0] IDX_CHROM = 8'd1;

endpackage

// File: rtl/dn_byte_fifo.sv
// Small synchronous byte FIFO with flush; read data comes straight from the storage registers.
module dn_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so push is legal on a full FIFO then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dn_loader_tx.sv
// Sources the ROM download port: buffers a byte stream and emits paced,
// auto-incrementing single-cycle writes.
module dn_loader_tx
  import dn_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned GAP        = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        index_in,
  input  logic [ADDR_W:0]   length,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [7:0]        dn_index,
  output logic              dn_download,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]      GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  dn_state_t         state, state_nxt;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W:0]   accepted;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        gap_cnt;

  logic       len_ok;
  logic       take_start;
  logic       reject;
  logic       pop;
  logic       push;
  logic       flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;

  assign len_ok  = (length != '0) && (length <= LEN_MAX);
  assign busy    = (state != ST_IDLE);
  assign s_ready = busy && !fifo_full && (accepted < len_q);
  assign push    = s_valid && s_ready;

  dn_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .din     (s_data),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    reject     = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len_ok) begin
            take_start = 1'b1;
            state_nxt  = ST_XFER;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (abort) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!fifo_empty) begin
          pop = 1'b1;
          if (remaining == (ADDR_W+1)'(1)) state_nxt = ST_FIN;
          else if (GAP > 0)                state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end else if (gap_cnt == '0) begin
          state_nxt = ST_XFER;
        end
      end
      ST_FIN: begin
        flush     = abort;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_wr       <= 1'b0;
      dn_addr     <= '0;
      dn_data     <= '0;
      dn_index    <= '0;
      dn_download <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      len_q       <= '0;
      remaining   <= '0;
      accepted    <= '0;
      addr        <= '0;
      gap_cnt     <= '0;
    end else begin
      dn_wr <= pop;
      err   <= reject;
      done  <= (state == ST_FIN) && !abort;
      if (take_start) begin
        dn_index    <= index_in;
        len_q       <= length;
        remaining   <= length;
        accepted    <= '0;
        addr        <= '0;
        dn_download <= 1'b1;
      end
      if (flush || state == ST_FIN) dn_download <= 1'b0;
      if (push) accepted <= accepted + (ADDR_W+1)'(1);
      // The final write leaves addr in place so a full-size transfer never wraps.
      if (pop) begin
        dn_addr   <= addr;
        dn_data   <= fifo_dout;
        remaining <= remaining - (ADDR_W+1)'(1);
        if (remaining != (ADDR_W+1)'(1)) addr <= addr + ADDR_W'(1);
      end
      if (pop)                                gap_cnt <= GAP_LD;
      else if (state == ST_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_dn_loader_tx.sv
// Directed bench for dn_loader_tx: reset, paced writes, length limiting, rejects, abort, full-size transfer.
module tb_dn_loader_tx;
  import dn_pkg::*;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned GAP    = 1;
  localparam int unsigned DEPTH  = 4;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [7:0]        index_in;
  logic [ADDR_W:0]   length;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic [7:0]        dn_index;
  logic              dn_download;
  logic              busy;
  logic              done;
  logic              err;

  dn_loader_tx #(.ADDR_W(ADDR_W), .GAP(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .index_in    (index_in),
    .length      (length),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wr       (dn_wr),
    .dn_index    (dn_index),
    .dn_download (dn_download),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // byte source: src_n bytes of value src_base+i, offered with probability src_pct
  int         src_n = 0;
  int         src_idx = 0;
  int         src_hs = 0;
  int         src_pct = 100;
  logic [7:0] src_base = 8'h00;

  initial begin
    s_valid = 1'b0;
    s_data  = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (src_idx < src_n && $urandom_range(99) < src_pct) begin
        s_valid = 1'b1;
        s_data  = src_base + 8'(src_idx);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (s_valid && s_ready) begin
        src_idx++;
        src_hs++;
      end
    end
  end

  // write monitor: expects addr == write number and data == src_base + write number
  int wr_n = 0, wr_bad = 0, wr_nodl = 0, wr_after_done = 0;
  int done_n = 0, done_cyc = 0, last_wr_cyc = 0;
  int wr_cyc [8];

  always @(negedge clk_sys) begin
    if (dn_wr) begin
      if (dn_addr !== ADDR_W'(wr_n) || dn_data !== src_base + 8'(wr_n)) wr_bad++;
      if (!dn_download) wr_nodl++;
      if (done_n > 0) wr_after_done++;
      if (wr_n < 8) wr_cyc[wr_n] = cyc;
      last_wr_cyc = cyc;
      wr_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic mon_clear();
    wr_n = 0; wr_bad = 0; wr_nodl = 0; wr_after_done = 0;
    done_n = 0; done_cyc = 0; last_wr_cyc = 0;
  endtask

  task automatic src_load(input int n, input logic [7:0] base, input int pct);
    src_idx = 0; src_hs = 0; src_n = n; src_base = base; src_pct = pct;
  endtask

  task automatic do_start(input logic [7:0] idx, input logic [ADDR_W:0] len);
    index_in = idx;
    length   = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_n == 0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(done_n == 0), 0);
  endtask

  initial begin
    int k;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; index_in = '0; length = '0;
    #1;
    check("rst_dn_wr", dn_wr, 0);
    check("rst_dn_download", dn_download, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_dn_addr", dn_addr, 0);
    check("rst_done_err", {done, err}, 0);
    repeat (3) @(posedge clk_sys);
    #2 reset_n = 1'b1;
    tick();

    // four bytes, GAP=1: writes two cycles apart, done one cycle after the last
    src_load(4, 8'hA0, 100);
    mon_clear();
    do_start(IDX_PGROM, 4);
    check("t2_download_at_start", dn_download, 1);
    check("t2_busy", busy, 1);
    wait_done("t2", 100);
    check("t2_wr_count", wr_n, 4);
    check("t2_addr_data", wr_bad, 0);
    check("t2_download_during_wr", wr_nodl, 0);
    for (int i = 0; i < 3; i++) check("t2_spacing", wr_cyc[i+1] - wr_cyc[i], 2);
    check("t2_done_latency", done_cyc - last_wr_cyc, 1);
    check("t2_download_after", dn_download, 0);
    check("t2_busy_after", busy, 0);
    check("t2_index", dn_index, IDX_PGROM);

    // length=3 with five bytes on offer
    src_load(5, 8'hB0, 100);
    mon_clear();
    do_start(IDX_CHROM, 3);
    wait_done("t3", 100);
    repeat (4) tick();
    check("t3_handshakes", src_hs, 3);
    check("t3_wr_count", wr_n, 3);
    check("t3_addr_data", wr_bad, 0);
    check("t3_s_ready", s_ready, 0);
    check("t3_index_held", dn_index, IDX_CHROM);
    src_n = 0;

    // rejected lengths and start while busy
    do_start(8'h00, 0);
    check("t4_err_len0", err, 1);
    check("t4_busy_len0", busy, 0);
    tick();
    check("t4_err_pulse", err, 0);
    do_start(8'h00, 15'd16385);
    check("t4_err_len_over", err, 1);
    check("t4_busy_over", busy, 0);
    tick();
    src_load(0, 8'h00, 100);
    mon_clear();
    do_start(IDX_PGROM, 2);
    check("t4_busy_stall", busy, 1);
    do_start(8'h05, 0);
    check("t4_busy_start_no_err", err, 0);
    check("t4_busy_start_index", dn_index, IDX_PGROM);
    check("t4_still_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_idle", busy, 0);
    check("t4_abort_no_done", done_n, 0);

    // abort after two of eight writes, then a one-byte transfer
    src_load(8, 8'hC0, 100);
    mon_clear();
    do_start(IDX_PGROM, 8);
    k = 0;
    while (wr_n < 2 && k < 200) begin
      tick();
      k++;
    end
    check("t6_reach_two", 32'(wr_n >= 2), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_download_off", dn_download, 0);
    check("t6_busy_off", busy, 0);
    check("t6_wr_off", dn_wr, 0);
    repeat (20) tick();
    check("t6_wr_count", wr_n, 2);
    check("t6_no_done", done_n, 0);
    src_load(1, 8'h5A, 100);
    mon_clear();
    do_start(IDX_PGROM, 1);
    wait_done("t6b", 100);
    check("t6b_wr_count", wr_n, 1);
    check("t6b_addr_data", wr_bad, 0);

    // asynchronous reset in the middle of a write
    src_load(8, 8'h50, 100);
    mon_clear();
    do_start(IDX_CHROM, 8);
    k = 0;
    while (!(dn_wr && dn_addr != '0) && k < 200) begin
      tick();
      k++;
    end
    check("t1_mid_write", {31'd0, dn_wr}, 1);
    reset_n = 1'b0;
    #1;
    check("t1_dn_wr", dn_wr, 0);
    check("t1_dn_download", dn_download, 0);
    check("t1_busy", busy, 0);
    check("t1_s_ready", s_ready, 0);
    check("t1_index_addr_data", {dn_index, 10'd0, dn_addr, dn_data}, 0);
    #20 reset_n = 1'b1;
    tick();
    src_load(1, 8'h6B, 100);
    mon_clear();
    do_start(IDX_PGROM, 1);
    wait_done("t1b", 100);
    check("t1b_wr_count", wr_n, 1);
    check("t1b_addr_data", wr_bad, 0);

    // full-size transfer with an irregular source
    src_load(16384, 8'h37, 75);
    mon_clear();
    do_start(IDX_CHROM, 15'd16384);
    wait_done("t5", 60000);
    repeat (10) tick();
    check("t5_wr_count", wr_n, 16384);
    check("t5_order", wr_bad, 0);
    check("t5_download_during_wr", wr_nodl, 0);
    check("t5_one_done", done_n, 1);
    check("t5_no_wr_after_done", wr_after_done, 0);
    check("t5_last_addr", dn_addr, 16383);
    check("t5_handshakes", src_hs, 16384);
    check("t5_index", dn_index, IDX_CHROM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
